// File: rtl/rv_hazard_pkg.sv
// Shared types and default parameters for the RV32 hazard/stall controller.
package rv_hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN,
        WAIT,
        ABORT
    } state_t;

    localparam int DEF_REG_AW      = 5;
    localparam int DEF_FWD_EN      = 1;
    localparam int DEF_MEM_TIMEOUT = 255;
    localparam int DEF_TO_W        = 8;
    localparam int DEF_CNT_W       = 32;

endpackage

// File: rtl/rv_hazard_unit_v2_if.sv
// Pipeline <-> hazard unit signal bundle; master is the datapath, slave the hazard unit.
interface rv_hazard_unit_v2_if #(
    parameter int REG_AW = rv_hazard_pkg::DEF_REG_AW,
    parameter int CNT_W  = rv_hazard_pkg::DEF_CNT_W
);
    import rv_hazard_pkg::*;

    logic [REG_AW-1:0] rs1_D, rs2_D, rs1_E, rs2_E;
    logic [REG_AW-1:0] rdest_E, rdest_M, rdest_W;
    logic              RegWrite_E, RegWrite_M, RegWrite_W;
    logic              Load_E, PCSrc_E;
    logic              dmem_req_M, dmem_ready, perf_clr;
    fwd_sel_t          ForwardA_E, ForwardB_E;
    logic              Stall_F, Stall_D, Stall_E, Stall_M;
    logic              Flush_D, Flush_E, Flush_W;
    logic              mem_err;
    logic [CNT_W-1:0]  stall_cycles, flush_count;

    modport master (
        output rs1_D, rs2_D, rs1_E, rs2_E, rdest_E, rdest_M, rdest_W,
               RegWrite_E, RegWrite_M, RegWrite_W, Load_E, PCSrc_E,
               dmem_req_M, dmem_ready, perf_clr,
        input  ForwardA_E, ForwardB_E, Stall_F, Stall_D, Stall_E, Stall_M,
               Flush_D, Flush_E, Flush_W, mem_err, stall_cycles, flush_count
    );

    modport slave (
        input  rs1_D, rs2_D, rs1_E, rs2_E, rdest_E, rdest_M, rdest_W,
               RegWrite_E, RegWrite_M, RegWrite_W, Load_E, PCSrc_E,
               dmem_req_M, dmem_ready, perf_clr,
        output ForwardA_E, ForwardB_E, Stall_F, Stall_D, Stall_E, Stall_M,
               Flush_D, Flush_E, Flush_W, mem_err, stall_cycles, flush_count
    );

endinterface

// File: rtl/rv_sat_counter.sv
// Saturating up-counter with synchronous clear that overrides increment.
module rv_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/rv_hazard_unit_v2.sv
// Hazard controller: forwarding, load-use/RAW stalls, branch flush, dmem freeze with timeout.
module rv_hazard_unit_v2
    import rv_hazard_pkg::*;
#(
    parameter int REG_AW      = DEF_REG_AW,
    parameter int FWD_EN      = DEF_FWD_EN,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int TO_W        = DEF_TO_W,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    rv_hazard_unit_v2_if.slave  hz
);

    localparam logic [REG_AW-1:0] X0       = '0;
    localparam logic [TO_W-1:0]   TO_LIMIT = TO_W'(MEM_TIMEOUT);

    // x0 is hardwired to zero, so it never creates a dependency.
    function automatic logic hit(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs);
        return (rd != X0) && (rd == rs);
    endfunction

    state_t           state, state_nxt;
    logic [TO_W-1:0]  cnt, cnt_nxt, cnt_inc;
    logic             freeze, lw_stall, raw_stall, data_stall;

    // The ABORT cycle releases the pipeline even though the access never completed.
    assign freeze = hz.dmem_req_M & ~hz.dmem_ready & (state != ABORT);

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_nxt = RUN;
        cnt_nxt   = '0;
        cnt_inc   = cnt + TO_W'(1);
        if (freeze) begin
            if (cnt_inc == TO_LIMIT) begin
                state_nxt = ABORT;
            end else begin
                state_nxt = WAIT;
                cnt_nxt   = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign hz.mem_err = (state == ABORT);

    always_comb begin
        hz.ForwardA_E = FWD_RF;
        hz.ForwardB_E = FWD_RF;
        if (FWD_EN != 0) begin
            if (hz.RegWrite_M && hit(hz.rdest_M, hz.rs1_E))      hz.ForwardA_E = FWD_M;
            else if (hz.RegWrite_W && hit(hz.rdest_W, hz.rs1_E)) hz.ForwardA_E = FWD_W;
            if (hz.RegWrite_M && hit(hz.rdest_M, hz.rs2_E))      hz.ForwardB_E = FWD_M;
            else if (hz.RegWrite_W && hit(hz.rdest_W, hz.rs2_E)) hz.ForwardB_E = FWD_W;
        end
    end

    always_comb begin
        lw_stall  = hz.Load_E & (hit(hz.rdest_E, hz.rs1_D) | hit(hz.rdest_E, hz.rs2_D));
        // Write-first regfile covers W, so only E and M producers stall without forwarding.
        raw_stall = (FWD_EN == 0) &&
                    ((hz.RegWrite_E && (hit(hz.rdest_E, hz.rs1_D) || hit(hz.rdest_E, hz.rs2_D))) ||
                     (hz.RegWrite_M && (hit(hz.rdest_M, hz.rs1_D) || hit(hz.rdest_M, hz.rs2_D))));
        data_stall = lw_stall | raw_stall;

        hz.Stall_F = 1'b0;
        hz.Stall_D = 1'b0;
        hz.Stall_E = 1'b0;
        hz.Stall_M = 1'b0;
        hz.Flush_D = 1'b0;
        hz.Flush_E = 1'b0;
        hz.Flush_W = 1'b0;
        if (freeze) begin
            hz.Stall_F = 1'b1;
            hz.Stall_D = 1'b1;
            hz.Stall_E = 1'b1;
            hz.Stall_M = 1'b1;
            hz.Flush_W = 1'b1;
        end else begin
            hz.Stall_F = data_stall;
            hz.Stall_D = data_stall;
            hz.Flush_E = data_stall | hz.PCSrc_E;
            hz.Flush_D = hz.PCSrc_E;
        end
    end

    rv_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (hz.perf_clr),
        .inc   (freeze | data_stall),
        .q     (hz.stall_cycles)
    );

    rv_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (hz.perf_clr),
        .inc   (hz.PCSrc_E & ~freeze),
        .q     (hz.flush_count)
    );

endmodule

// File: tb/tb_rv_hazard_unit_v2.sv
// Scoreboard bench: dut A forwards (32-bit counters), dut B has no forwarding (4-bit counters).
module tb_rv_hazard_unit_v2;
    import rv_hazard_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rv_hazard_unit_v2_if #(.REG_AW(5), .CNT_W(32)) hz_a ();
    rv_hazard_unit_v2_if #(.REG_AW(5), .CNT_W(4))  hz_b ();

    rv_hazard_unit_v2 #(.REG_AW(5), .FWD_EN(1), .MEM_TIMEOUT(4), .TO_W(8), .CNT_W(32)) u_a (
        .clk(clk), .reset(reset), .hz(hz_a.slave));
    rv_hazard_unit_v2 #(.REG_AW(5), .FWD_EN(0), .MEM_TIMEOUT(4), .TO_W(8), .CNT_W(4)) u_b (
        .clk(clk), .reset(reset), .hz(hz_b.slave));

    typedef struct packed {
        logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rdest_E, rdest_M, rdest_W;
        logic       we_E, we_M, we_W, load_E, pcsrc, req, ready, clr;
    } stim_t;

    typedef struct packed {
        logic       sel;
        logic [1:0] fwd_a, fwd_b;
        logic [3:0] stall;
        logic [2:0] flush;
        logic       mem_err;
    } exp_t;

    localparam stim_t IDLE = '0;
    localparam logic [3:0] ST_FRZ = 4'b1111;
    localparam logic [3:0] ST_DAT = 4'b1100;

    exp_t  exp_q[$];
    int    errors = 0;
    int    checks = 0;
    stim_t s;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic sel, input logic [1:0] fa, input logic [1:0] fb,
                                input logic [3:0] st, input logic [2:0] fl, input logic me);
        exp_t e;
        e.sel = sel; e.fwd_a = fa; e.fwd_b = fb; e.stall = st; e.flush = fl; e.mem_err = me;
        return e;
    endfunction

    task automatic apply(input stim_t v);
        hz_a.rs1_D = v.rs1_D;   hz_b.rs1_D = v.rs1_D;
        hz_a.rs2_D = v.rs2_D;   hz_b.rs2_D = v.rs2_D;
        hz_a.rs1_E = v.rs1_E;   hz_b.rs1_E = v.rs1_E;
        hz_a.rs2_E = v.rs2_E;   hz_b.rs2_E = v.rs2_E;
        hz_a.rdest_E = v.rdest_E; hz_b.rdest_E = v.rdest_E;
        hz_a.rdest_M = v.rdest_M; hz_b.rdest_M = v.rdest_M;
        hz_a.rdest_W = v.rdest_W; hz_b.rdest_W = v.rdest_W;
        hz_a.RegWrite_E = v.we_E; hz_b.RegWrite_E = v.we_E;
        hz_a.RegWrite_M = v.we_M; hz_b.RegWrite_M = v.we_M;
        hz_a.RegWrite_W = v.we_W; hz_b.RegWrite_W = v.we_W;
        hz_a.Load_E = v.load_E;   hz_b.Load_E = v.load_E;
        hz_a.PCSrc_E = v.pcsrc;   hz_b.PCSrc_E = v.pcsrc;
        hz_a.dmem_req_M = v.req;  hz_b.dmem_req_M = v.req;
        hz_a.dmem_ready = v.ready; hz_b.dmem_ready = v.ready;
        hz_a.perf_clr = v.clr;    hz_b.perf_clr = v.clr;
    endtask

    task automatic compare(input string name);
        exp_t e;
        logic [1:0] fa, fb;
        logic [3:0] st;
        logic [2:0] fl;
        logic       me;
        e = exp_q.pop_front();
        if (e.sel == 1'b0) begin
            fa = hz_a.ForwardA_E; fb = hz_a.ForwardB_E;
            st = {hz_a.Stall_F, hz_a.Stall_D, hz_a.Stall_E, hz_a.Stall_M};
            fl = {hz_a.Flush_D, hz_a.Flush_E, hz_a.Flush_W};
            me = hz_a.mem_err;
        end else begin
            fa = hz_b.ForwardA_E; fb = hz_b.ForwardB_E;
            st = {hz_b.Stall_F, hz_b.Stall_D, hz_b.Stall_E, hz_b.Stall_M};
            fl = {hz_b.Flush_D, hz_b.Flush_E, hz_b.Flush_W};
            me = hz_b.mem_err;
        end
        check({name, ".fwd_a"},   32'(fa), 32'(e.fwd_a));
        check({name, ".fwd_b"},   32'(fb), 32'(e.fwd_b));
        check({name, ".stall"},   32'(st), 32'(e.stall));
        check({name, ".flush"},   32'(fl), 32'(e.flush));
        check({name, ".mem_err"}, 32'(me), 32'(e.mem_err));
    endtask

    // Called at a falling edge: drive, push expectation, compare mid-cycle, advance one clock.
    task automatic step(input string name, input stim_t v, input exp_t e);
        apply(v);
        exp_q.push_back(e);
        #2;
        compare(name);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1);
    end

    initial begin
        apply(IDLE);
        repeat (2) @(negedge clk);
        check("rst.stall_a", hz_a.stall_cycles, 0);
        check("rst.flush_a", hz_a.flush_count, 0);
        check("rst.err_a", 32'(hz_a.mem_err), 0);
        check("rst.stall_b", 32'(hz_b.stall_cycles), 0);
        reset = 1'b1;
        @(negedge clk);

        s = IDLE; s.we_M = 1; s.rdest_M = 5; s.we_W = 1; s.rdest_W = 5; s.rs1_E = 5;
        step("fwd_m_pri", s, mk(0, 2'b10, 2'b00, 4'b0, 3'b0, 0));
        s = IDLE; s.we_W = 1; s.rdest_W = 5; s.rs1_E = 5; s.rs2_E = 5;
        step("fwd_w", s, mk(0, 2'b01, 2'b01, 4'b0, 3'b0, 0));
        s = IDLE; s.we_M = 1; s.we_W = 1;
        step("fwd_x0", s, mk(0, 2'b00, 2'b00, 4'b0, 3'b0, 0));
        s = IDLE; s.we_M = 1; s.rdest_M = 9; s.rs2_E = 9; s.rs1_E = 3; s.we_W = 1; s.rdest_W = 3;
        step("fwd_b_m", s, mk(0, 2'b01, 2'b10, 4'b0, 3'b0, 0));
        s = IDLE; s.rdest_M = 9; s.rs1_E = 9;
        step("fwd_nowe", s, mk(0, 2'b00, 2'b00, 4'b0, 3'b0, 0));

        s = IDLE; s.load_E = 1; s.rdest_E = 6; s.rs2_D = 6;
        step("lw_stall", s, mk(0, 2'b00, 2'b00, ST_DAT, 3'b010, 0));
        step("lw_release", IDLE, mk(0, 2'b00, 2'b00, 4'b0, 3'b0, 0));
        s = IDLE; s.load_E = 1;
        step("lw_x0", s, mk(0, 2'b00, 2'b00, 4'b0, 3'b0, 0));
        check("lw.stall_cycles", hz_a.stall_cycles, 1);

        s = IDLE; s.load_E = 1; s.rdest_E = 6; s.rs1_D = 6; s.pcsrc = 1;
        step("br_lw", s, mk(0, 2'b00, 2'b00, ST_DAT, 3'b110, 0));
        check("br.stall_cycles", hz_a.stall_cycles, 2);
        check("br.flush_count", hz_a.flush_count, 1);

        s = IDLE; s.req = 1; s.pcsrc = 1;
        repeat (3) step("freeze_br", s, mk(0, 2'b00, 2'b00, ST_FRZ, 3'b001, 0));
        s.ready = 1;
        step("freeze_rel", s, mk(0, 2'b00, 2'b00, 4'b0, 3'b110, 0));
        check("frz.stall_cycles", hz_a.stall_cycles, 5);
        check("frz.flush_count", hz_a.flush_count, 2);

        s = IDLE; s.req = 1;
        repeat (4) step("to_wait", s, mk(0, 2'b00, 2'b00, ST_FRZ, 3'b001, 0));
        step("to_abort", s, mk(0, 2'b00, 2'b00, 4'b0, 3'b0, 1));
        step("to_after", IDLE, mk(0, 2'b00, 2'b00, 4'b0, 3'b0, 0));
        check("to.stall_cycles", hz_a.stall_cycles, 9);

        s = IDLE; s.req = 1;
        repeat (3) step("rdy_wait", s, mk(0, 2'b00, 2'b00, ST_FRZ, 3'b001, 0));
        s.ready = 1;
        step("rdy_last", s, mk(0, 2'b00, 2'b00, 4'b0, 3'b0, 0));
        step("rdy_after", IDLE, mk(0, 2'b00, 2'b00, 4'b0, 3'b0, 0));
        check("rdy.stall_cycles", hz_a.stall_cycles, 12);
        check("rdy.flush_count", hz_a.flush_count, 2);

        s = IDLE; s.load_E = 1; s.rdest_E = 6; s.rs1_D = 6; s.pcsrc = 1; s.clr = 1;
        step("clr", s, mk(0, 2'b00, 2'b00, ST_DAT, 3'b110, 0));
        check("clr.stall_a", hz_a.stall_cycles, 0);
        check("clr.flush_a", hz_a.flush_count, 0);
        check("clr.stall_b", 32'(hz_b.stall_cycles), 0);

        s = IDLE; s.we_M = 1; s.rdest_M = 7; s.rs1_D = 7; s.rs1_E = 7;
        step("nofwd_m", s, mk(1, 2'b00, 2'b00, ST_DAT, 3'b010, 0));
        step("fwd_same", s, mk(0, 2'b10, 2'b00, 4'b0, 3'b0, 0));
        s = IDLE; s.we_E = 1; s.rdest_E = 3; s.rs2_D = 3;
        step("nofwd_e", s, mk(1, 2'b00, 2'b00, ST_DAT, 3'b010, 0));
        s = IDLE; s.we_W = 1; s.rdest_W = 4; s.rs1_D = 4; s.rs1_E = 4;
        step("nofwd_w", s, mk(1, 2'b00, 2'b00, 4'b0, 3'b0, 0));
        s = IDLE; s.we_M = 1; s.we_E = 1;
        step("nofwd_x0", s, mk(1, 2'b00, 2'b00, 4'b0, 3'b0, 0));
        check("nofwd.stall_b", 32'(hz_b.stall_cycles), 3);
        s = IDLE; s.we_M = 1; s.rdest_M = 7; s.rs2_D = 7;
        for (int i = 0; i < 20; i++) step("sat", s, mk(1, 2'b00, 2'b00, ST_DAT, 3'b010, 0));
        check("sat.stall_b", 32'(hz_b.stall_cycles), 15);
        check("sat.stall_a", hz_a.stall_cycles, 0);

        s = IDLE; s.req = 1;
        repeat (2) step("pre_rst", s, mk(0, 2'b00, 2'b00, ST_FRZ, 3'b001, 0));
        #2;
        reset = 1'b0;
        #1;
        check("midrst.stall_a", hz_a.stall_cycles, 0);
        check("midrst.err_a", 32'(hz_a.mem_err), 0);
        check("midrst.stall_b", 32'(hz_b.stall_cycles), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) step("post_rst", s, mk(0, 2'b00, 2'b00, ST_FRZ, 3'b001, 0));
        step("post_abort", s, mk(0, 2'b00, 2'b00, 4'b0, 3'b0, 1));
        step("post_idle", IDLE, mk(0, 2'b00, 2'b00, 4'b0, 3'b0, 0));
        check("post.stall_a", hz_a.stall_cycles, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
